// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Provides the op encodings driven by decode, the sequencer state
// encoding, and the default datapath and counter widths.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MTHI  = 2'b10,
    MD_MTLO  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider datapath.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load_mul, load_div  latch operands on the accepting edge
//   step, is_div        advance one iteration, choosing divide or multiply
//   rs_data, rt_data    operands
//   nxt_hi, nxt_lo      combinational result of the current iteration
//                       (the final product/remainder-quotient on the last step)
module muldiv_datapath #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mul,
  input  logic              load_div,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] nxt_hi,
  output logic [DATA_W-1:0] nxt_lo
);

  // a: accumulator high half / remainder
  // b: accumulator low half with the multiplier shifting out of it / quotient
  // m: multiplicand / divisor
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
    div_shift = {a_q, b_q[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    // When div_ge holds the difference is below the divisor, so the top
    // bit of the wide subtraction is always zero and can be dropped.
    div_diff  = div_shift[DATA_W-1:0] - m_q;

    if (is_div) begin
      nxt_hi = div_ge ? div_diff : div_shift[DATA_W-1:0];
      nxt_lo = {b_q[DATA_W-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[DATA_W:1];
      nxt_lo = {mul_sum[0], b_q[DATA_W-1:1]};
    end

    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    if (load_mul) begin
      a_d = '0;
      b_d = rt_data;
      m_d = rs_data;
    end else if (load_div) begin
      a_d = '0;
      b_d = rs_data;
      m_d = rt_data;
    end else if (step) begin
      a_d = nxt_hi;
      b_d = nxt_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer with HI/LO registers and pipeline stall.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, op         issue request and op code (MULTU/DIVU/MTHI/MTLO)
//   rs_data, rt_data  operands
//   hilo_rd_req       MFHI/MFLO in EX this cycle
//   flush             squash an in-flight operation
//   hi, lo            committed HI/LO
//   busy, stall       operation in flight / hold front of pipeline
//   done              one-cycle pulse after commit
//   div_zero          sticky: last accepted DIVU had a zero divisor
//
// state | meaning
// IDLE  | accepts new ops; MTHI/MTLO complete here in one edge
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int CNT_W  = mips_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              hilo_rd_req,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic              div_zero
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  // div_zero as it was before the current DIVU, restored if that DIVU is flushed
  logic              dz_save_q, dz_save_d;

  logic              accept, last, load_mul, load_div, step;
  logic [DATA_W-1:0] nxt_hi, nxt_lo;

  assign busy     = (state_q != IDLE);
  assign stall    = busy & (hilo_rd_req | start);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign accept   = (state_q == IDLE) & start & ~flush;
  assign last     = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    dz_save_d = dz_save_q;
    load_mul  = 1'b0;
    load_div  = 1'b0;
    step      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            MD_MULTU: begin
              state_d  = MUL;
              cnt_d    = '0;
              load_mul = 1'b1;
            end
            MD_DIVU: begin
              state_d   = DIV;
              cnt_d     = '0;
              load_div  = 1'b1;
              dz_save_d = dz_q;
              dz_d      = (rt_data == '0);
            end
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == DIV) dz_d = dz_save_q;
        end else begin
          step = 1'b1;
          if (last) begin
            hi_d    = nxt_hi;
            lo_d    = nxt_lo;
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_save_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      dz_save_q <= dz_save_d;
    end
  end

  muldiv_datapath #(.DATA_W(DATA_W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_mul (load_mul),
    .load_div (load_div),
    .step     (step),
    .is_div   (state_q == DIV),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .nxt_hi   (nxt_hi),
    .nxt_lo   (nxt_lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl. Inputs change and outputs are sampled
// on the falling edge; cycle k is the period following rising edge k-1,
// with start presented in cycle 0.
module tb_muldiv_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hilo_rd_req, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hilo_rd_req (hilo_rd_req),
    .flush       (flush),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present an op in the current cycle; returns in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  // From cycle 1, advance until done (bounded); n is the cycle done appeared in.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    check("done_latency", 64'(n), 64'd33);
  endtask

  initial begin
    int n, busy_cnt, done_cnt, stall_cnt;
    rst = 1'b1; start = 1'b0; hilo_rd_req = 1'b0; flush = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // MULTU 7 x 6 with exact latency
    issue(MD_MULTU, 32'd7, 32'd6);
    busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      cyc();
    end
    check("mul1_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul1_no_early_done", 64'(done_cnt), 64'd0);
    check("mul1_busy33", 64'(busy), 64'd0);
    check("mul1_done33", 64'(done), 64'd1);
    check("mul1_lo", 64'(lo), 64'h2A);
    check("mul1_hi", 64'(hi), 64'd0);
    cyc();
    check("mul1_done_pulse", 64'(done), 64'd0);

    // MULTU max x max
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("mul2_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul2_lo", 64'(lo), 64'h1);
    cyc();

    // DIVU 100 / 7
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(n);
    check("div1_lo", 64'(lo), 64'd14);
    check("div1_hi", 64'(hi), 64'd2);
    check("div1_dz", 64'(div_zero), 64'd0);
    cyc();

    // DIVU by zero, then a normal DIVU clears the flag on accept
    issue(MD_DIVU, 32'h1234_5678, 32'd0);
    wait_done(n);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'h1234_5678);
    check("div0_dz", 64'(div_zero), 64'd1);
    cyc();
    check("div0_dz_sticky", 64'(div_zero), 64'd1);
    issue(MD_DIVU, 32'd9, 32'd3);
    check("div2_dz_accept", 64'(div_zero), 64'd0);
    wait_done(n);
    check("div2_lo", 64'(lo), 64'd3);
    check("div2_hi", 64'(hi), 64'd0);
    cyc();

    // Stall from HI/LO reads and an ignored second start
    issue(MD_MULTU, 32'h0001_0000, 32'h0003_0000);
    stall_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      hilo_rd_req = (c >= 5);
      start       = (c == 10);
      op          = MD_MTLO;
      rs_data     = 32'hDEAD;
      #1;
      if (stall) stall_cnt++;
      if (c == 10) check("stall_on_start", 64'(stall), 64'd1);
      if (c == 4)  check("no_stall_before_rd", 64'(stall), 64'd0);
      cyc();
    end
    start = 1'b0;
    #1;
    check("stall_cycles", 64'(stall_cnt), 64'd28);
    check("stall_drop33", 64'(stall), 64'd0);
    check("stall_done33", 64'(done), 64'd1);
    check("stall_hi", 64'(hi), 64'd3);
    check("stall_lo_ignored_mtlo", 64'(lo), 64'd0);
    hilo_rd_req = 1'b0;
    cyc();

    // MTHI / MTLO preload
    issue(MD_MTHI, 32'hAAAA, 32'd0);
    check("mthi_hi", 64'(hi), 64'hAAAA);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(MD_MTLO, 32'h5555, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h5555);
    check("mtlo_busy", 64'(busy), 64'd0);

    // Flush a MULTU at cycle 10
    issue(MD_MULTU, 32'd3, 32'd3);
    repeat (9) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_busy11", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'hAAAA);
    check("flush_lo", 64'(lo), 64'h5555);
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) done_cnt++;
      cyc();
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);

    // Flushed DIVU by zero restores div_zero
    issue(MD_DIVU, 32'd5, 32'd0);
    check("fdiv_dz_set", 64'(div_zero), 64'd1);
    repeat (2) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("fdiv_dz_restored", 64'(div_zero), 64'd0);
    check("fdiv_busy", 64'(busy), 64'd0);
    check("fdiv_hi", 64'(hi), 64'hAAAA);

    // flush with start in IDLE: start ignored
    flush = 1'b1;
    issue(MD_MTHI, 32'h1234, 32'd0);
    flush = 1'b0;
    check("idle_flush_start_hi", 64'(hi), 64'hAAAA);
    check("idle_flush_start_busy", 64'(busy), 64'd0);

    // Reset mid-DIVU at cycle 15, with a start in the same cycle
    issue(MD_DIVU, 32'h1234_5678, 32'd0);
    check("rdiv_dz_set", 64'(div_zero), 64'd1);
    repeat (14) cyc();
    rst = 1'b1;
    op = MD_MULTU; rs_data = 32'd2; rt_data = 32'd2; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_dz", 64'(div_zero), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    cyc();
    check("mrst_start_ignored", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer with HI/LO storage for the 5-stage pipeline. It executes MULTU/DIVU over 32 cycles, so the single-cycle ALU is not widened. It also handles MTHI/MTLO writes and raises a pipeline stall when a HI/LO consumer or a new mul/div arrives while an operation is in flight. It sits beside the ALU in EX; its op code comes from decode, in the same role the ALU function code plays for the ALU.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.
CNT_W, 5, iteration counter width; must equal clog2(DATA_W).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  issue request from EX, qualified by op.
op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
rs_data  in  DATA_W  multiplicand / dividend / MTHI-MTLO source.
rt_data  in  DATA_W  multiplier / divisor.
hilo_rd_req  in  1  MFHI or MFLO present in EX this cycle.
flush  in  1  squash any in-flight operation.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.
busy  out  1  an operation is in flight.
stall  out  1  hold IF/ID/EX, bubble MEM.
done  out  1  one-cycle pulse after HI/LO commit.
div_zero  out  1  sticky flag: last DIVU had divisor 0.

Behaviour:
- Reset: synchronous and active-high. When rst=1 at a clk edge: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, cnt=0. rst overrides start and flush. Reset mid-operation discards partial results.
- States:
  - IDLE -> MUL on start&op=00.
  - IDLE -> DIV on start&op=01.
  - MUL/DIV -> IDLE when cnt==DATA_W-1, or on flush.
- Accept in IDLE, edge 0:
  - MULTU: latch multiplicand=rs_data and multiplier=rt_data; clear the 2*DATA_W accumulator; cnt=0.
  - DIVU: latch dividend into the quotient shift register; latch divisor; clear the remainder. div_zero <= (rt_data==0).
- MUL, each cycle: shift-add, one multiplier bit per cycle, LSB first. Unsigned, with a DATA_W+1-bit partial sum to keep the carry.
- DIV, each cycle: restoring division, one quotient bit per cycle. Shift {rem,quo} left by 1; if rem >= divisor, subtract and set the quotient LSB. Width is DATA_W+1 for the compare.
- Commit on the edge where cnt==DATA_W-1, i.e. the 32nd iteration:
  - MULTU: hi=product[63:32], lo=product[31:0].
  - DIVU: hi=remainder, lo=quotient.
  - Then done=1 for exactly the next cycle and state=IDLE.
  - Latency: start at edge 0; busy=1 on cycles 1..32; new HI/LO and done=1 visible in cycle 33.
- Divide by zero: no special path. The natural restoring result is lo=all-ones and hi=dividend. div_zero stays set until the next DIVU accept or reset.
- MTHI/MTLO in IDLE: hi or lo = rs_data on the accepting edge; no busy, no done.
- start while busy: ignored, any op. stall is asserted so the pipeline holds the instruction and re-presents it.
- stall = busy & (hilo_rd_req | start). Combinational from registered busy; it drops in the commit-visible cycle, so MFHI/MFLO then reads the new value.
- hi/lo are readable at any time. While busy they hold the previous committed values.
- flush while busy: state=IDLE next edge, hi/lo unchanged, done=0, div_zero restored to its pre-accept value. flush in IDLE has no effect. flush together with a start in IDLE: start is ignored.
- Counter: cnt increments only in MUL/DIV and clears on accept. No wrap is reachable.

Decomposition:
- Shared package (mips_pkg): op encodings MD_MULTU/MD_DIVU/MD_MTHI/MD_MTLO; state enum IDLE/MUL/DIV; DATA_W constant.
- One natural sub-module: muldiv_datapath, holding the shift registers, adder/subtractor and compare, steered by muldiv_ctrl's state and cnt. muldiv_ctrl keeps the FSM, counter, HI/LO, stall and flags.

Test Plan:
- MULTU 7 x 6 at cycle 0 -> busy cycles 1..32; cycle 33: lo=0x0000002A, hi=0, done=1 for one cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU 100/7 -> lo=14, hi=2, div_zero=0.
- DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1; a following DIVU 9/3 -> div_zero=0, lo=3, hi=0.
- MULTU in flight, hilo_rd_req=1 from cycle 5 -> stall=1 on cycles 5..32, stall=0 in cycle 33 with new hi/lo. A second start at cycle 10 -> ignored, stall=1.
- Preload MTHI 0xAAAA, MTLO 0x5555 (1 cycle each, no busy); MULTU 3x3; flush at cycle 10 -> busy=0 at cycle 11, hi=0xAAAA, lo=0x5555, no done.
- DIVU in flight, rst at cycle 15 -> cycle 16: hi=lo=0, busy=0, div_zero=0. A start in the same cycle as rst is ignored.
